// File: rtl/srf_writeback_queue.sv
// Write-back queue between a vector producer and the SRF write port: FIFO-ordered
// buffering, a registered write strobe/address/data, and a reader-side hazard probe.
module srf_writeback_queue #(
    parameter int NUM_STREAM_ID       = 5,
    parameter int MIN_VEC_LENGTH      = 16,
    parameter int NUM_TILES_PER_SLICE = 20,
    parameter int QUEUE_DEPTH         = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_STREAM_ID-1:0]         in_stream_dest,
    input  logic [MIN_VEC_LENGTH-1:0]        in_data [NUM_TILES_PER_SLICE],
    input  logic                             srf_stall,
    input  logic                             flush,
    output logic                             srf_write_enable,
    output logic [NUM_STREAM_ID-1:0]         stream_dest,
    output logic [MIN_VEC_LENGTH-1:0]        write_data [NUM_TILES_PER_SLICE],
    input  logic [NUM_STREAM_ID-1:0]         hazard_src,
    output logic                             hazard_hit,
    output logic [$clog2(QUEUE_DEPTH):0]     occupancy,
    output logic                             idle,
    output logic [15:0]                      writes_issued
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_STREAM_ID-1:0]  dest_mem_r [QUEUE_DEPTH];
    logic [MIN_VEC_LENGTH-1:0] data_mem_r [QUEUE_DEPTH][NUM_TILES_PER_SLICE];

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic [PTR_W-1:0] probe_idx_s;
    logic             hit_s;

    assign full_s    = (count_r == CNT_W'(QUEUE_DEPTH));
    // Gated by rst so the producer never sees a ready while the queue is held in reset.
    assign in_ready  = rst & ~full_s;
    assign occupancy = count_r;
    assign idle      = (count_r == {CNT_W{1'b0}}) & ~srf_write_enable;
    assign hazard_hit = hit_s;

    // Push/pop qualification and next pointer/count values; flush wins over both.
    always_comb begin
        push_s        = 1'b0;
        pop_s         = 1'b0;
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        count_next_s  = count_r;
        if (flush) begin
            rd_ptr_next_s = {PTR_W{1'b0}};
            wr_ptr_next_s = {PTR_W{1'b0}};
            count_next_s  = {CNT_W{1'b0}};
        end else begin
            push_s = in_valid & in_ready;
            pop_s  = (count_r != {CNT_W{1'b0}}) & ~srf_stall;
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_next_s = count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_next_s = count_r - CNT_W'(1);
            end else begin
                count_next_s = count_r;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Entry storage; left unreset because only slots below count_r are ever observed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            dest_mem_r[wr_ptr_r] <= in_stream_dest;
            for (int i = 0; i < NUM_TILES_PER_SLICE; i++) begin
                data_mem_r[wr_ptr_r][i] <= in_data[i];
            end
        end
    end

    // Registered SRF write port: strobe every pop, address/data hold between pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            srf_write_enable <= 1'b0;
            stream_dest      <= {NUM_STREAM_ID{1'b0}};
            for (int i = 0; i < NUM_TILES_PER_SLICE; i++) begin
                write_data[i] <= {MIN_VEC_LENGTH{1'b0}};
            end
        end else if (pop_s) begin
            srf_write_enable <= 1'b1;
            stream_dest      <= dest_mem_r[rd_ptr_r];
            for (int i = 0; i < NUM_TILES_PER_SLICE; i++) begin
                write_data[i] <= data_mem_r[rd_ptr_r][i];
            end
        end else begin
            srf_write_enable <= 1'b0;
        end
    end

    // Issued-write counter, free-running modulo 2^16.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writes_issued <= 16'h0000;
        end else if (pop_s) begin
            writes_issued <= writes_issued + 16'h0001;
        end else begin
            writes_issued <= writes_issued;
        end
    end

    // Hazard probe: scan live entries from the head, plus the write currently on the port.
    always_comb begin
        hit_s       = 1'b0;
        probe_idx_s = rd_ptr_r;
        for (int j = 0; j < QUEUE_DEPTH; j++) begin
            probe_idx_s = rd_ptr_r + PTR_W'(j);
            if ((CNT_W'(j) < count_r) && (dest_mem_r[probe_idx_s] == hazard_src)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        if (srf_write_enable && (stream_dest == hazard_src)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = hit_s;
        end
    end

endmodule

// File: doc/srf_writeback_queue.md
SRF_WRITEBACK_QUEUE -- requirements
Module: srf_writeback_queue

Interface
REQ-001 Parameter NUM_STREAM_ID, default 5: width of a stream identifier.
REQ-002 Parameter MIN_VEC_LENGTH, default 16: bits per tile element.
REQ-003 Parameter NUM_TILES_PER_SLICE, default 20: elements per vector.
REQ-004 Parameter QUEUE_DEPTH, default 4: entry count, power of two, at least 2.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  producer presents a result vector.
REQ-008 in_ready  output  1  queue can accept this cycle.
REQ-009 in_stream_dest  input  NUM_STREAM_ID  destination stream of the offered vector.
REQ-010 in_data  input  MIN_VEC_LENGTH x NUM_TILES_PER_SLICE (unpacked)  offered vector.
REQ-011 srf_stall  input  1  SRF write port unavailable this cycle.
REQ-012 flush  input  1  synchronous discard of all queued entries.
REQ-013 srf_write_enable  output  1  registered write strobe to the SRF.
REQ-014 stream_dest  output  NUM_STREAM_ID  registered SRF write address.
REQ-015 write_data  output  MIN_VEC_LENGTH x NUM_TILES_PER_SLICE (unpacked)  registered SRF write vector.
REQ-016 hazard_src  input  NUM_STREAM_ID  stream id queried by the reader side.
REQ-017 hazard_hit  output  1  hazard_src has a write pending or in flight.
REQ-018 occupancy  output  $clog2(QUEUE_DEPTH)+1  queued entry count.
REQ-019 idle  output  1  no queued entry and no write in flight.
REQ-020 writes_issued  output  16  count of SRF writes issued.

Function
REQ-021 in_ready SHALL be (occupancy != QUEUE_DEPTH) and SHALL be 0 while rst is low; it SHALL NOT depend on in_valid or the same-cycle pop.
REQ-022 A push SHALL occur at a posedge with in_valid=1 and in_ready=1; the entry holds in_stream_dest and all NUM_TILES_PER_SLICE elements of in_data.
REQ-023 A pop SHALL occur at a posedge with occupancy>0, srf_stall=0 and flush=0; the head is loaded into stream_dest/write_data and srf_write_enable is set to 1.
REQ-024 At any posedge without a pop, srf_write_enable SHALL be set to 0; stream_dest and write_data SHALL hold their values.
REQ-025 Entries SHALL issue in strict FIFO order; nothing is dropped or duplicated except by flush.
REQ-026 Latency: an entry pushed at edge k into an empty queue with srf_stall=0 SHALL pop at edge k+1, with srf_write_enable=1 during cycle k+1 to k+2; there is no same-edge bypass.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged; when full, in_ready stays 0 even if a pop occurs that cycle.
REQ-028 Read and write pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-029 flush=1 at a posedge SHALL set occupancy to 0, reset both pointers and clear srf_write_enable; flush overrides push and pop in that cycle, and writes_issued is unchanged.
REQ-030 hazard_hit SHALL be combinational and equal 1 iff some valid queued entry has dest==hazard_src, or srf_write_enable=1 and stream_dest==hazard_src.
REQ-031 idle SHALL equal (occupancy==0) and (srf_write_enable==0).
REQ-032 writes_issued SHALL increment by 1 on each pop and wrap from 16'hFFFF to 0.
REQ-033 srf_stall SHALL block pops only; pushes continue until the queue is full.

Reset
REQ-034 While rst=0, independent of clk: occupancy=0, pointers=0, srf_write_enable=0, stream_dest=0, write_data all 0, writes_issued=0, in_ready=0, hazard_hit=0, idle=1.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries and any in-flight write; operation resumes at the first posedge after rst rises.
REQ-036 Queue storage contents need no reset; unused entries SHALL NOT affect any output.

Verification
REQ-037 Single write: push dest=3 with element[i]=i+1, srf_stall=0 -> the next edge gives srf_write_enable=1 for one cycle, stream_dest=3, write_data[19]=20, writes_issued=1.
REQ-038 Fill under stall: srf_stall=1, push dests 1,2,3,4 -> occupancy=4, in_ready=0, no write; release srf_stall -> writes to 1,2,3,4 on 4 consecutive cycles, then idle=1.
REQ-039 Full with simultaneous push and pop: full queue, srf_stall=0, in_valid=1 -> a pop occurs, in_ready is 0 for that cycle, the push is accepted next cycle, and order is preserved.
REQ-040 Hazard: queue holds dests 0 and 4 -> hazard_src=4 gives hazard_hit=1; after the dest 4 write retires, hazard_hit=0; hazard_src=7 always gives 0.
REQ-041 Flush: occupancy=3 with flush and in_valid both 1 -> occupancy=0 and srf_write_enable=0 next cycle, and the offered entry is not stored.
REQ-042 Reset mid-drain: drop rst while srf_write_enable=1 with occupancy=2 -> outputs immediately equal the REQ-034 values, and no write occurs after rst rises.
